// File: rtl/switch_arbiter.sv
// Packet-aware round-robin arbiter draining N_PORTS input FIFOs into a
// single byte stream. Each packet is a length header followed by that many
// payload bytes; the grant is held for the whole packet.
module switch_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int FIFO_WIDTH = 8,
  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              fifo_empty,
  input  logic [N_PORTS*FIFO_WIDTH-1:0]   fifo_data,
  output logic [N_PORTS-1:0]              fifo_read_en,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [FIFO_WIDTH-1:0]           out_data,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [GW-1:0]                   grant,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  localparam logic [FIFO_WIDTH-1:0] ONE = FIFO_WIDTH'(1);

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  // bytes of the current packet still expected to arrive on fifo_data
  logic [FIFO_WIDTH-1:0] remaining_q, remaining_d;
  // payload bytes not yet requested from the FIFO
  logic [FIFO_WIDTH-1:0] to_read_q, to_read_d;
  // a read was issued last cycle, so fifo_data carries a byte now
  logic                  inflight_q, inflight_d;

  logic [FIFO_WIDTH-1:0] port_data [N_PORTS];
  logic [GW-1:0]         cand_idx  [N_PORTS];
  logic [N_PORTS-1:0]    cand_vld;
  logic                  rr_found;
  logic [GW-1:0]         rr_sel;
  logic [FIFO_WIDTH-1:0] cur_data;
  logic                  can_issue;
  logic [N_PORTS-1:0]    rd_en;
  logic                  beat_valid, beat_sop, beat_eop;

  // Unpack data lanes; candidate k is the port k+1 places after last_grant.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign port_data[gi] = fifo_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    assign cand_idx[gi]  = GW'((int'(last_grant_q) + gi + 1) % N_PORTS);
    assign cand_vld[gi]  = !fifo_empty[cand_idx[gi]];
  end

  assign cur_data  = port_data[grant_q];
  assign can_issue = !fifo_empty[grant_q] && out_ready;

  // Round-robin pick: nearest non-empty port after the last grant wins.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        rr_found = 1'b1;
        rr_sel   = cand_idx[k];
      end
    end
  end

  // Next-state, read issue and output beat decode.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    to_read_d    = to_read_q;
    inflight_d   = 1'b0;
    rd_en        = '0;
    beat_valid   = 1'b0;
    beat_sop     = 1'b0;
    beat_eop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (out_ready && rr_found) begin
          grant_d       = rr_sel;
          rd_en[rr_sel] = 1'b1;
          inflight_d    = 1'b1;
          state_d       = HDR;
        end
      end
      HDR: begin
        // Payload reads may only start once the header is visible.
        if (inflight_q) begin
          beat_valid = 1'b1;
          beat_sop   = 1'b1;
          if (cur_data == '0) begin
            beat_eop     = 1'b1;
            state_d      = IDLE;
            last_grant_d = grant_q;
          end else begin
            remaining_d = cur_data;
            to_read_d   = cur_data;
            state_d     = PAYLOAD;
            if (can_issue) begin
              rd_en[grant_q] = 1'b1;
              to_read_d      = cur_data - ONE;
              inflight_d     = 1'b1;
            end
          end
        end
      end
      PAYLOAD: begin
        if (inflight_q) begin
          beat_valid  = 1'b1;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            beat_eop     = 1'b1;
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
        if ((to_read_q != '0) && can_issue) begin
          rd_en[grant_q] = 1'b1;
          to_read_d      = to_read_q - ONE;
          inflight_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_PORTS - 1);
      remaining_q  <= '0;
      to_read_q    <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      to_read_q    <= to_read_d;
      inflight_q   <= inflight_d;
    end
  end

  // Read strobes are forced low while reset is held, even if FIFOs have data.
  assign fifo_read_en = rst ? rd_en : '0;
  assign out_valid    = beat_valid;
  assign out_sop      = beat_sop;
  assign out_eop      = beat_eop;
  assign out_data     = beat_valid ? cur_data : '0;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_switch_arbiter.sv
// Scoreboard bench for switch_arbiter: bench-side FIFOs, a packet-level
// round-robin reference model, and a monitor checking every output beat.
module tb_switch_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int GW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     fifo_empty = '1;
  logic [N*W-1:0]   fifo_data;
  logic [N-1:0]     fifo_read_en;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_sop;
  logic             out_eop;
  logic [GW-1:0]    grant;
  logic             busy;

  switch_arbiter #(.N_PORTS(N), .FIFO_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    d;
    logic          sop;
    logic          eop;
    logic [GW-1:0] port;
  } beat_t;

  logic [7:0] fq [N][$];   // contents of the bench FIFOs seen by the DUT
  logic [7:0] mq [N][$];   // model copy of loaded, not-yet-predicted bytes
  logic [7:0] fd_q [N];
  beat_t      sb [$];
  logic       stall = 1'b0;
  int         model_last = N - 1;
  int         total = 0;
  int         bad = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_data
    assign fifo_data[gi*W +: W] = fd_q[gi];
  end

  initial begin
    for (int p = 0; p < N; p++) fd_q[p] = '0;
  end

  // One-cycle read latency FIFO behaviour.
  always @(posedge clk) begin
    for (int p = 0; p < N; p++) begin
      if (fifo_read_en[p] && fq[p].size() > 0) fd_q[p] <= fq[p].pop_front();
    end
  end

  // Empty flags settle mid-cycle, well before the next sampling edge.
  always @(negedge clk) begin
    for (int p = 0; p < N; p++) fifo_empty[p] = stall || (fq[p].size() == 0);
  end

  // Monitor: rule checks every cycle, scoreboard compare on each beat.
  logic prev_rd = 1'b0;
  logic prev_eop_beat = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (rst) begin
      total++;
      if (($countones(fifo_read_en) > 1) || ((fifo_read_en & fifo_empty) != '0) ||
          ((fifo_read_en != '0) && !out_ready) ||
          (busy && ((fifo_read_en & ~(4'b0001 << grant)) != '0))) begin
        bad++;
        $display("FAIL read_en_rule: read_en=%b empty=%b ready=%0d grant=%0d busy=%0d",
                 fifo_read_en, fifo_empty, out_ready, grant, busy);
      end
      total++;
      if (out_valid !== prev_rd) begin
        bad++;
        $display("FAIL read_latency: out_valid=%0d required=%0d (read one cycle earlier)",
                 out_valid, prev_rd);
      end
      if (prev_eop_beat) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_after_eop: busy=%0d required=0", busy);
        end
      end
      if (out_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: data=%h sop=%0d eop=%0d grant=%0d required no beat",
                   out_data, out_sop, out_eop, grant);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || grant !== e.port) begin
            bad++;
            $display("FAIL beat: got data=%h sop=%0d eop=%0d port=%0d required data=%h sop=%0d eop=%0d port=%0d",
                     out_data, out_sop, out_eop, grant, e.d, e.sop, e.eop, e.port);
          end
        end
      end
      prev_rd       = (fifo_read_en != '0);
      prev_eop_beat = out_valid && out_eop;
    end else begin
      prev_rd       = 1'b0;
      prev_eop_beat = 1'b0;
    end
  end

  task automatic load_packet(input int p, input int len);
    logic [7:0] b;
    fq[p].push_back(8'(len));
    mq[p].push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      fq[p].push_back(b);
      mq[p].push_back(b);
    end
  endtask

  // Predict the output stream: serve whole packets, next port after the last served.
  task automatic commit();
    int  p;
    int  len;
    bit  any;
    beat_t e;
    forever begin
      any = 1'b0;
      p   = 0;
      for (int k = 1; k <= N; k++) begin
        p = (model_last + k) % N;
        if (mq[p].size() > 0) begin
          any = 1'b1;
          break;
        end
      end
      if (!any) break;
      len    = int'(mq[p].pop_front());
      e.d    = 8'(len);
      e.sop  = 1'b1;
      e.eop  = (len == 0);
      e.port = GW'(p);
      sb.push_back(e);
      for (int i = 0; i < len; i++) begin
        e.d   = mq[p].pop_front();
        e.sop = 1'b0;
        e.eop = (i == len - 1);
        sb.push_back(e);
      end
      model_last = p;
    end
  endtask

  function automatic bit fifos_empty();
    for (int p = 0; p < N; p++) if (fq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic flush_all();
    for (int p = 0; p < N; p++) begin
      fq[p].delete();
      mq[p].delete();
    end
    sb.delete();
  endtask

  // Run until everything loaded has been forwarded; random or windowed stalls/backpressure.
  task automatic run_phase(input string name, input bit rnd, input int s_at, input int s_len,
                           input int r_at, input int r_len);
    int c = 0;
    bit done = 1'b0;
    while (!done && c < 3000) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        stall     = ($urandom_range(0, 4) == 0);
      end else begin
        stall     = (c >= s_at) && (c < s_at + s_len);
        out_ready = !((c >= r_at) && (c < r_at + r_len));
      end
      @(posedge clk);
      #2;
      c++;
      done = (sb.size() == 0) && !busy && fifos_empty();
    end
    out_ready = 1'b1;
    stall     = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_%s: pending beats=%0d busy=%0d after %0d cycles, required drained",
               name, sb.size(), busy, c);
      flush_all();
      rst = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      model_last = N - 1;
    end else begin
      $display("phase %s done in %0d cycles", name, c);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_data !== '0 ||
        fifo_read_en !== '0 || grant !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: valid=%0d sop=%0d eop=%0d data=%h rd=%b grant=%0d busy=%0d required all zero",
               name, out_valid, out_sop, out_eop, out_data, fifo_read_en, grant, busy);
    end
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset_state");
    rst = 1'b1;

    // Round robin from reset: ports 0,2,3 then a second packet on 0.
    load_packet(0, 1); load_packet(2, 1); load_packet(3, 1); load_packet(0, 1);
    commit();
    run_phase("round_robin", 1'b0, 0, 0, 0, 0);

    // Single 3-byte packet on port 1.
    load_packet(1, 3);
    commit();
    run_phase("single", 1'b0, 0, 0, 0, 0);

    // Zero-length packet.
    load_packet(0, 0);
    commit();
    run_phase("zero_len", 1'b0, 0, 0, 0, 0);

    // Underflow stall in the middle of a packet.
    load_packet(2, 4);
    commit();
    run_phase("stall", 1'b0, 4, 3, 0, 0);

    // Backpressure in the middle of a payload.
    load_packet(3, 6);
    commit();
    run_phase("backpressure", 1'b0, 0, 0, 4, 2);

    // Reset during payload abandons the packet; port 0 wins afterwards.
    load_packet(2, 8);
    commit();
    c = 0;
    while (sb.size() > 5 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_packet");
    flush_all();
    model_last = N - 1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    load_packet(1, 2); load_packet(0, 3); load_packet(3, 1);
    commit();
    run_phase("after_reset", 1'b0, 0, 0, 0, 0);

    // Randomised traffic with random stalls and backpressure.
    for (int ph = 0; ph < 40; ph++) begin
      for (int p = 0; p < N; p++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int j = 0; j < np; j++) load_packet(p, $urandom_range(0, 6));
      end
      commit();
      run_phase($sformatf("random_%0d", ph), 1'b1, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_arbiter.md
SWITCH_ARBITER -- requirements
Module: switch_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of input FIFOs arbitrated.
REQ-002 SHALL have parameter FIFO_WIDTH, default 8: byte width of each FIFO data path.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port fifo_empty, input, N_PORTS: per-port empty flag from input FIFOs.
REQ-006 SHALL have port fifo_data, input, N_PORTS*FIFO_WIDTH: per-port FIFO read data; port i at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 SHALL have port fifo_read_en, output, N_PORTS: per-port read strobe, at most one bit high per cycle.
REQ-008 SHALL have port out_ready, input, 1: downstream permission to issue new reads.
REQ-009 SHALL have port out_valid, output, 1: out_data carries a forwarded byte this cycle.
REQ-010 SHALL have port out_data, output, FIFO_WIDTH: forwarded byte.
REQ-011 SHALL have port out_sop / out_eop, output, 1 each: first / last byte of packet, qualified by out_valid.
REQ-012 SHALL have port grant, output, clog2(N_PORTS): index of port currently owning output.
REQ-013 SHALL have port busy, output, 1: high while a packet is in progress (state != IDLE).

Function
REQ-014 Packet format SHALL be: header byte L (payload length, 0..2^FIFO_WIDTH-1), then L payload bytes; header forwarded as first output byte.
REQ-015 States SHALL be IDLE, HDR, PAYLOAD.
REQ-016 IDLE: if any fifo_empty bit low and out_ready high, SHALL select port by round-robin, load grant, assert fifo_read_en[grant] same cycle, go to HDR.
REQ-017 Round-robin SHALL search ports starting at (last_grant+1) mod N_PORTS, wrapping; last_grant reset value N_PORTS-1 so port 0 has first priority.
REQ-018 FIFO read latency SHALL be one cycle: byte read on cycle t appears on fifo_data at t+1; out_valid/out_data SHALL be driven at t+1 from fifo_data[grant].
REQ-019 HDR: on arrival of header byte SHALL assert out_valid, out_sop, latch L into remaining counter; if L=0 assert out_eop same beat and return to IDLE, else go to PAYLOAD.
REQ-020 Read issue SHALL occur in any cycle where !fifo_empty[grant], out_ready high, and reads issued < bytes owed; no read issued otherwise.
REQ-021 PAYLOAD: each arriving byte SHALL decrement remaining; byte with remaining==1 SHALL carry out_eop; then state IDLE, last_grant<=grant.
REQ-022 Reads SHALL be pipelined: back-to-back bytes at one per cycle when FIFO non-empty and out_ready high; header read and first payload read SHALL NOT overlap (payload reads start the cycle header arrives).
REQ-023 Grant SHALL be held for the whole packet; fifo_empty on granted port mid-packet SHALL stall (no timeout, no preemption).
REQ-024 out_ready low SHALL block new reads only; a byte already in flight SHALL still be presented with out_valid the next cycle (sink absorbs one beat after dropping ready).
REQ-025 fifo_read_en SHALL never assert on a port whose fifo_empty is high, nor on a non-granted port.
REQ-026 Returning to IDLE SHALL allow a new grant no earlier than the cycle after out_eop.

Reset
REQ-027 On rst low, asynchronously: state IDLE, fifo_read_en 0, out_valid 0, out_sop 0, out_eop 0, out_data 0, grant 0, busy 0, remaining 0, last_grant N_PORTS-1.
REQ-028 Reset mid-packet SHALL abandon the packet with no further output; FIFO contents untouched.

Verification
REQ-029 Single packet: port 1 holds [0x03,A,B,C], others empty, out_ready=1 -> grant=1, four consecutive out_valid beats 03,A,B,C, sop on 03, eop on C, busy drops next cycle.
REQ-030 Round robin: ports 0,2,3 each hold one packet L=1 -> service order 0,2,3; then new packet on 0 -> served after 3.
REQ-031 Zero length: port 0 holds [0x00] -> one beat 00 with sop and eop both high, back to IDLE.
REQ-032 Underflow stall: port 2 packet L=4 with fifo_empty high for 3 cycles after byte 2 -> no read_en during stall, grant stays 2, bytes resume in order, eop on byte 4.
REQ-033 Backpressure: out_ready low for 2 cycles mid-payload -> at most one in-flight beat emitted after ready drops, no bytes lost or duplicated.
REQ-034 Reset mid-packet: rst low during PAYLOAD -> all outputs 0 immediately, next grant after release goes to port 0 if non-empty.
